// File: rtl/direction_ctrl.sv
// Snake heading controller: debounces four push buttons, buffers up to two
// legal turns, and applies one buffered turn per movement tick.
module direction_ctrl #(
  parameter int DEB_CNT     = 500000,
  parameter int MOVE_PERIOD = 12500000
) (
  input  logic       master_clk,
  input  logic       rst_n,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       freeze,
  output logic [1:0] direction,
  output logic       movement_clk,
  output logic       turn_dropped
);

  localparam int DW = (DEB_CNT > 1) ? $clog2(DEB_CNT) : 1;
  localparam int TW = (MOVE_PERIOD > 1) ? $clog2(MOVE_PERIOD) : 1;
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CNT - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(MOVE_PERIOD - 1);

  typedef enum logic [1:0] {
    DIR_LEFT  = 2'd0,
    DIR_RIGHT = 2'd1,
    DIR_UP    = 2'd2,
    DIR_DOWN  = 2'd3
  } dir_e;

  // Button vectors are indexed by the heading code each button requests.
  logic [3:0] btn_raw;
  assign btn_raw = {btn_down, btn_up, btn_right, btn_left};

  logic [3:0]    sync1_q, sync2_q;
  logic [3:0]    deb_q, deb_d;
  logic [DW-1:0] deb_cnt_q [4];
  logic [DW-1:0] deb_cnt_d [4];
  logic [3:0]    press;

  logic [TW-1:0] tick_q, tick_d;

  dir_e       fifo_q [2];
  dir_e       fifo_d [2];
  logic [1:0] fifo_cnt_q, fifo_cnt_d;
  dir_e       direction_q, direction_d;
  logic       drop_q, drop_d;

  logic cand_vld, multi_press, accept, push, pop;
  dir_e cand, ref_dir;

  // Debounce: a level change is accepted only after DEB_CNT stable cycles.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      deb_d[i]     = deb_q[i];
      deb_cnt_d[i] = '0;
      if (sync2_q[i] != deb_q[i]) begin
        if (deb_cnt_q[i] == DEB_LAST) begin
          deb_d[i] = sync2_q[i];
        end else begin
          deb_cnt_d[i] = deb_cnt_q[i] + DW'(1);
        end
      end
    end
  end

  assign press = deb_d & ~deb_q;

  // Same-cycle presses: up > down > left > right; the losers count as a drop.
  always_comb begin
    cand_vld    = |press;
    multi_press = (press & (press - 4'd1)) != 4'd0;
    cand        = DIR_RIGHT;
    if (press[DIR_UP])         cand = DIR_UP;
    else if (press[DIR_DOWN])  cand = DIR_DOWN;
    else if (press[DIR_LEFT])  cand = DIR_LEFT;
    else if (press[DIR_RIGHT]) cand = DIR_RIGHT;
  end

  assign movement_clk = (tick_q == TICK_LAST) && !freeze;
  assign tick_d       = freeze ? tick_q
                      : (tick_q == TICK_LAST) ? '0 : tick_q + TW'(1);

  // Legality is judged against the last heading that will be in effect.
  always_comb begin
    ref_dir = direction_q;
    if (fifo_cnt_q == 2'd2)      ref_dir = fifo_q[1];
    else if (fifo_cnt_q == 2'd1) ref_dir = fifo_q[0];
  end

  assign pop    = movement_clk && (fifo_cnt_q != 2'd0);
  assign accept = cand_vld && !freeze && (cand != ref_dir)
                  && (cand != dir_e'(ref_dir ^ 2'b01));
  assign push   = accept && !((fifo_cnt_q == 2'd2) && !pop);
  assign drop_d = !freeze && cand_vld
                  && (multi_press || (accept && !push));

  always_comb begin
    fifo_d      = fifo_q;
    fifo_cnt_d  = fifo_cnt_q;
    direction_d = direction_q;
    if (pop) begin
      direction_d = fifo_q[0];
      fifo_d[0]   = fifo_q[1];
      fifo_cnt_d  = fifo_cnt_q - 2'd1;
    end
    if (push) begin
      fifo_d[fifo_cnt_d[0]] = cand;
      fifo_cnt_d            = fifo_cnt_d + 2'd1;
    end
    if (freeze) begin
      fifo_cnt_d = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge master_clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      deb_q       <= '0;
      for (int i = 0; i < 4; i++) begin
        deb_cnt_q[i] <= '0;
      end
      tick_q      <= '0;
      // NOTE: the two FIFO slots are reset too; they are tiny and this keeps
      // the head free of X even though fifo_cnt_q alone marks validity.
      fifo_q[0]   <= DIR_LEFT;
      fifo_q[1]   <= DIR_LEFT;
      fifo_cnt_q  <= '0;
      direction_q <= DIR_RIGHT;
      drop_q      <= 1'b0;
    end else begin
      sync1_q     <= btn_raw;
      sync2_q     <= sync1_q;
      deb_q       <= deb_d;
      for (int i = 0; i < 4; i++) begin
        deb_cnt_q[i] <= deb_cnt_d[i];
      end
      tick_q      <= tick_d;
      fifo_q      <= fifo_d;
      fifo_cnt_q  <= fifo_cnt_d;
      direction_q <= direction_d;
      drop_q      <= drop_d;
    end
  end

  assign direction    = direction_q;
  assign turn_dropped = drop_q;

endmodule

// File: tb/tb_direction_ctrl.sv
// Self-checking bench for direction_ctrl: directed scenarios plus random
// button/freeze traffic, compared every cycle with a queue-based reference.
module tb_direction_ctrl;

  localparam int DEB = 4;
  localparam int PER = 10;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn_left = 1'b0, btn_right = 1'b0, btn_up = 1'b0, btn_down = 1'b0;
  logic       freeze = 1'b0;
  logic [1:0] direction;
  logic       movement_clk, turn_dropped;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  direction_ctrl #(.DEB_CNT(DEB), .MOVE_PERIOD(PER)) dut (
    .master_clk   (clk),
    .rst_n        (rst_n),
    .btn_left     (btn_left),
    .btn_right    (btn_right),
    .btn_up       (btn_up),
    .btn_down     (btn_down),
    .freeze       (freeze),
    .direction    (direction),
    .movement_clk (movement_clk),
    .turn_dropped (turn_dropped)
  );

  // Reference model state: heading, tick phase, pending-turn queue.
  int m_dir;
  int m_tick;
  int m_fifo [$];
  bit m_drop;
  bit m_s1 [4];
  bit m_s2 [4];
  bit m_deb [4];
  int m_run [4];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, expv, $time);
    end
  endtask

  function automatic bit raw_btn(input int b);
    case (b)
      0:       return btn_left;
      1:       return btn_right;
      2:       return btn_up;
      default: return btn_down;
    endcase
  endfunction

  task automatic model_reset();
    m_dir  = 1;
    m_tick = 0;
    m_fifo.delete();
    m_drop = 1'b0;
    for (int b = 0; b < 4; b++) begin
      m_s1[b] = 1'b0; m_s2[b] = 1'b0; m_deb[b] = 1'b0; m_run[b] = 0;
    end
  endtask

  task automatic model_step();
    bit pulse, drop, push;
    bit evt [4];
    int prio [4];
    int n, cand, refd;
    prio  = '{2, 3, 0, 1};
    pulse = (m_tick == PER - 1) && !freeze;
    n = 0; cand = -1; drop = 1'b0; push = 1'b0;
    for (int b = 0; b < 4; b++) begin
      evt[b] = 1'b0;
      if (m_s2[b] != m_deb[b]) begin
        m_run[b]++;
        if (m_run[b] == DEB) begin
          m_deb[b] = m_s2[b];
          m_run[b] = 0;
          evt[b]   = m_deb[b];
        end
      end else begin
        m_run[b] = 0;
      end
    end
    if (!freeze) begin
      for (int i = 0; i < 4; i++) begin
        if (evt[prio[i]]) begin
          n++;
          if (cand < 0) cand = prio[i];
        end
      end
      if (n > 1) drop = 1'b1;
      if (cand >= 0) begin
        refd = (m_fifo.size() > 0) ? m_fifo[$] : m_dir;
        if (cand != refd && cand != (refd ^ 1)) begin
          if (m_fifo.size() == 2 && !pulse) drop = 1'b1;
          else push = 1'b1;
        end
      end
    end
    if (pulse && m_fifo.size() > 0) m_dir = m_fifo.pop_front();
    if (push) m_fifo.push_back(cand);
    if (freeze) m_fifo.delete();
    if (!freeze) m_tick = (m_tick + 1) % PER;
    for (int b = 0; b < 4; b++) begin
      m_s2[b] = m_s1[b];
      m_s1[b] = raw_btn(b);
    end
    m_drop = drop;
  endtask

  // One clock: compare on the falling edge, advance the model on the rising one.
  task automatic cycle();
    @(negedge clk);
    check("direction", 32'(direction), 32'(m_dir));
    check("movement_clk", 32'(movement_clk), 32'((m_tick == PER - 1) && !freeze));
    check("turn_dropped", 32'(turn_dropped), 32'(m_drop));
    @(posedge clk);
    if (rst_n) model_step();
    else model_reset();
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic set_btns(input bit l, input bit r, input bit u, input bit d);
    btn_left = l; btn_right = r; btn_up = u; btn_down = d;
  endtask

  task automatic do_reset();
    set_btns(0, 0, 0, 0);
    rst_n = 1'b0;
    model_reset();
    run(3);
    rst_n = 1'b1;
  endtask

  task automatic wait_tick(input int v);
    int guard;
    guard = 0;
    while (m_tick != v && guard < 2 * PER) begin
      cycle();
      guard++;
    end
    if (guard >= 2 * PER) begin
      n_tests++;
      n_fail++;
      $display("FAIL wait_tick: phase %0d not reached, stuck at %0d", v, m_tick);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int hold [4];
    bit lvl [4];
    int fz_hold, drops, found;

    model_reset();
    run(3);
    check("reset_direction", 32'(direction), 32'd1);
    check("reset_movement", 32'(movement_clk), 32'd0);
    check("reset_dropped", 32'(turn_dropped), 32'd0);
    rst_n = 1'b1;

    // Idle: pulses in cycles 10, 20, 30 after reset release.
    for (int k = 1; k <= 31; k++) begin
      check("idle_pulse", 32'(movement_clk), 32'(k % 10 == 0));
      cycle();
    end
    check("idle_direction", 32'(direction), 32'd1);

    // Held up -> heading 2 after the next tick; short down glitch ignored.
    btn_up = 1'b1;
    run(8);
    btn_up = 1'b0;
    run(12);
    check("up_taken", 32'(direction), 32'd2);
    btn_down = 1'b1;
    run(2);
    btn_down = 1'b0;
    run(25);
    check("glitch_ignored", 32'(direction), 32'd2);

    // Reversal rejected silently, then up+left buffered as {2,0}.
    do_reset();
    btn_left = 1'b1;
    run(6);
    btn_left = 1'b0;
    run(20);
    check("reversal_rejected", 32'(direction), 32'd1);
    wait_tick(0);
    for (int k = 0; k < 10; k++) begin
      set_btns(k >= 2 && k < 8, 0, k < 6, 0);
      cycle();
    end
    check("fifo_first", 32'(direction), 32'd2);
    set_btns(0, 0, 0, 0);
    run(10);
    check("fifo_second", 32'(direction), 32'd0);
    run(10);

    // Full FIFO: down off-tick is dropped with a pulse.
    wait_tick(0);
    for (int k = 0; k < 10; k++) begin
      set_btns(k >= 2 && k < 8, 0, k < 6, k >= 3 && k < 9);
      if (k == 9) check("full_drop_pulse", 32'(turn_dropped), 32'd1);
      cycle();
    end
    set_btns(0, 0, 0, 0);
    check("full_drop_first", 32'(direction), 32'd2);
    run(10);
    check("full_drop_second", 32'(direction), 32'd0);
    run(10);
    check("full_drop_unchanged", 32'(direction), 32'd0);

    // Full FIFO: down landing in the tick cycle is accepted.
    wait_tick(0);
    for (int k = 0; k < 10; k++) begin
      set_btns(k >= 2 && k < 8, 0, k < 6, k >= 4 && k < 10);
      cycle();
    end
    set_btns(0, 0, 0, 0);
    check("pop_push_no_drop", 32'(turn_dropped), 32'd0);
    check("pop_push_first", 32'(direction), 32'd2);
    run(10);
    check("pop_push_second", 32'(direction), 32'd0);
    run(10);
    check("pop_push_third", 32'(direction), 32'd3);

    // Simultaneous up and left: up wins, exactly one drop pulse.
    do_reset();
    set_btns(1, 0, 1, 0);
    drops = 0;
    for (int k = 0; k < 15; k++) begin
      if (k == 6) set_btns(0, 0, 0, 0);
      if (turn_dropped === 1'b1) drops++;
      cycle();
    end
    check("simul_drop_count", 32'(drops), 32'd1);
    run(20);
    check("simul_up_wins", 32'(direction), 32'd2);

    // Random buttons and freeze windows against the reference model.
    for (int b = 0; b < 4; b++) hold[b] = 0;
    fz_hold = 0;
    for (int c = 0; c < 800; c++) begin
      for (int b = 0; b < 4; b++) begin
        if (hold[b] == 0) begin
          lvl[b]  = ($urandom_range(0, 3) == 0);
          hold[b] = $urandom_range(1, 12);
        end
        hold[b]--;
      end
      set_btns(lvl[0], lvl[1], lvl[2], lvl[3]);
      if (fz_hold == 0) begin
        freeze  = ($urandom_range(0, 7) == 0);
        fz_hold = $urandom_range(3, 20);
      end
      fz_hold--;
      cycle();
    end
    freeze = 1'b0;

    // Freeze at phase 5 with one turn buffered: flush, hold, resume.
    do_reset();
    wait_tick(7);
    for (int k = 0; k < 8; k++) begin
      btn_up = (k < 6);
      cycle();
    end
    freeze = 1'b1;
    for (int k = 0; k < 12; k++) begin
      check("frozen_no_pulse", 32'(movement_clk), 32'd0);
      cycle();
    end
    check("frozen_direction", 32'(direction), 32'd1);
    freeze = 1'b0;
    found = -1;
    for (int k = 0; k < 10; k++) begin
      if (found < 0 && movement_clk === 1'b1) found = k;
      if (found < 0) cycle();
    end
    check("resume_delay", 32'(found), 32'd4);
    cycle();
    check("flushed_direction", 32'(direction), 32'd1);

    // Asynchronous reset mid-tick and mid-debounce.
    btn_up = 1'b1;
    run(6);
    btn_up = 1'b0;
    run(25);
    check("pre_reset_direction", 32'(direction), 32'd2);
    wait_tick(4);
    btn_left = 1'b1;
    run(3);
    rst_n = 1'b0;
    model_reset();
    #1;
    check("async_reset_direction", 32'(direction), 32'd1);
    check("async_reset_movement", 32'(movement_clk), 32'd0);
    check("async_reset_dropped", 32'(turn_dropped), 32'd0);
    btn_left = 1'b0;
    run(3);
    rst_n = 1'b1;
    run(20);
    check("post_reset_direction", 32'(direction), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
